// File: rtl/ftdi_sync_pkg.sv
// ftdi_sync_pkg: shared FSM states, direction type and arbitration priority constants.
package ftdi_sync_pkg;
  typedef enum logic [2:0] {IDLE, RD_OE, RD, WR, TURN} state_t;
  typedef enum logic {DIR_RD, DIR_WR} dir_t;
  localparam int PRIO_READ = 0;
  localparam int PRIO_WRITE = 1;
  localparam int PRIO_RR = 2;
endpackage

// File: rtl/ftdi_burst_arbiter.sv
// ftdi_burst_arbiter: picks the next transfer direction and tracks words in the current burst.
module ftdi_burst_arbiter
  import ftdi_sync_pkg::*;
#(
  parameter int BURST_MAX = 64,
  parameter int PRIORITY = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_req,
  input  logic wr_req,
  input  logic word,
  input  logic clr,
  input  dir_t last_dir,
  output logic grant_rd,
  output logic grant_wr,
  output logic limit_hit
);
  localparam int CW = BURST_MAX > 0 ? $clog2(BURST_MAX + 1) : 1;
  logic [CW-1:0] burst_cnt;
  logic rd_first;
  always_comb rd_first = PRIORITY == PRIO_RR ? last_dir == DIR_WR : PRIORITY != PRIO_WRITE;
  assign grant_rd = rd_req & (~wr_req | rd_first);
  assign grant_wr = wr_req & ~grant_rd;
  assign limit_hit = BURST_MAX != 0 && word && burst_cnt == CW'(BURST_MAX - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) burst_cnt <= '0;
    else if (clr) burst_cnt <= '0;
    else if (word) burst_cnt <= burst_cnt + CW'(1);
endmodule

// File: rtl/ftdi_sync_fifo_axis_wide.sv
// ftdi_sync_fifo_axis_wide: FTDI sync-FIFO bridge with AXI-Stream ports and burst arbitration.
// Define FTDI_STATS_EN to generate the read/write word counters.
module ftdi_sync_fifo_axis_wide
  import ftdi_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BE_WIDTH = DATA_WIDTH / 8,
  parameter int BURST_MAX = 64,
  parameter int PRIORITY = 0
) (
  input  logic                  ftdi_clko,
  input  logic                  res,
  input  logic                  ftdi_rxf_n,
  input  logic                  ftdi_txe_n,
  output logic                  ftdi_rd_n,
  output logic                  ftdi_oe_n,
  output logic                  ftdi_wr_n,
  inout  wire  [DATA_WIDTH-1:0] ftdi_data,
  inout  wire  [BE_WIDTH-1:0]   ftdi_be,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [BE_WIDTH-1:0]   m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  m_axis_almost_full,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [BE_WIDTH-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  rd_overflow,
  output logic [31:0]           stat_rd_words,
  output logic [31:0]           stat_wr_words
);
  state_t state;
  dir_t last_dir;
  logic rd_req, wr_req, rd_word, wr_word, grant_rd, grant_wr, limit_hit, drive, drive_be;
  assign rd_req = ~ftdi_rxf_n & ~m_axis_almost_full;
  assign wr_req = ~ftdi_txe_n & s_axis_tvalid;
  assign m_axis_tvalid = ~ftdi_rxf_n & ~ftdi_rd_n;
  assign s_axis_tready = ~ftdi_txe_n & ~ftdi_wr_n;
  assign rd_word = m_axis_tvalid;
  assign wr_word = s_axis_tvalid & s_axis_tready;
  assign drive = ftdi_oe_n && state != TURN;
  // An 8-bit part has no BE pins, so the enable is held off.
  assign drive_be = drive && DATA_WIDTH != 8;
  assign ftdi_data = drive ? s_axis_tdata : 'z;
  assign ftdi_be = drive_be ? s_axis_tkeep : 'z;
  assign m_axis_tdata = ftdi_data;
  assign m_axis_tkeep = DATA_WIDTH == 8 ? '1 : ftdi_be;
  ftdi_burst_arbiter #(.BURST_MAX(BURST_MAX), .PRIORITY(PRIORITY)) u_arb (
    .clk(ftdi_clko), .rst(res), .rd_req(rd_req), .wr_req(wr_req),
    .word(rd_word | wr_word), .clr(state == IDLE), .last_dir(last_dir),
    .grant_rd(grant_rd), .grant_wr(grant_wr), .limit_hit(limit_hit)
  );
  always_ff @(posedge ftdi_clko or posedge res)
    if (res) begin
      state <= IDLE;
      ftdi_rd_n <= 1'b1;
      ftdi_oe_n <= 1'b1;
      ftdi_wr_n <= 1'b1;
      last_dir <= DIR_WR;
      rd_overflow <= 1'b0;
    end else begin
      if (m_axis_tvalid & ~m_axis_tready) rd_overflow <= 1'b1;
      case (state)
        IDLE:
          if (grant_rd) begin
            state <= RD_OE;
            ftdi_oe_n <= 1'b0;
          end else if (grant_wr) begin
            state <= WR;
            ftdi_wr_n <= 1'b0;
          end
        RD_OE: begin
          state <= RD;
          ftdi_rd_n <= 1'b0;
          last_dir <= DIR_RD;
        end
        RD: begin
          last_dir <= DIR_RD;
          if (!rd_req || limit_hit) begin
            state <= TURN;
            ftdi_rd_n <= 1'b1;
            ftdi_oe_n <= 1'b1;
          end
        end
        WR: begin
          last_dir <= DIR_WR;
          if (!wr_req || limit_hit) begin
            state <= TURN;
            ftdi_wr_n <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
`ifdef FTDI_STATS_EN
  always_ff @(posedge ftdi_clko or posedge res)
    if (res) begin
      stat_rd_words <= '0;
      stat_wr_words <= '0;
    end else begin
      if (rd_word) stat_rd_words <= stat_rd_words + 32'd1;
      if (wr_word) stat_wr_words <= stat_wr_words + 32'd1;
    end
`else
  assign stat_rd_words = '0;
  assign stat_wr_words = '0;
`endif
endmodule

// File: tb/tb_ftdi_sync_fifo_axis_wide.sv
// tb_ftdi_sync_fifo_axis_wide: FTDI-side and AXI-side models around a 32-bit, 4-word-burst, round-robin bridge.
module tb_ftdi_sync_fifo_axis_wide;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int BM = 4;
  localparam logic [31:0] IDLE_PAT = 32'hA5A5_A5A5;
  localparam byte CR = 8'h52;
  localparam byte CW = 8'h57;

  logic clk = 1'b0;
  logic res;
  logic ftdi_rxf_n, ftdi_txe_n, ftdi_rd_n, ftdi_oe_n, ftdi_wr_n;
  wire [DW-1:0] ftdi_data;
  wire [BW-1:0] ftdi_be;
  logic [DW-1:0] m_axis_tdata, s_axis_tdata;
  logic [BW-1:0] m_axis_tkeep, s_axis_tkeep;
  logic m_axis_tvalid, m_axis_tready, m_axis_almost_full, s_axis_tvalid, s_axis_tready;
  logic rd_overflow;
  logic [31:0] stat_rd_words, stat_wr_words;
  logic [DW-1:0] host_word;
  logic [BW-1:0] host_be;

  always #5 clk = ~clk;

  assign ftdi_data = ~ftdi_oe_n ? host_word : 'z;
  assign ftdi_be = ~ftdi_oe_n ? host_be : 'z;

  ftdi_sync_fifo_axis_wide #(.DATA_WIDTH(DW), .BURST_MAX(BM), .PRIORITY(2)) dut (
    .ftdi_clko(clk), .res(res), .ftdi_rxf_n(ftdi_rxf_n), .ftdi_txe_n(ftdi_txe_n),
    .ftdi_rd_n(ftdi_rd_n), .ftdi_oe_n(ftdi_oe_n), .ftdi_wr_n(ftdi_wr_n),
    .ftdi_data(ftdi_data), .ftdi_be(ftdi_be),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_almost_full(m_axis_almost_full),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .rd_overflow(rd_overflow),
    .stat_rd_words(stat_rd_words), .stat_wr_words(stat_wr_words)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] rd_q[$], s_q[$], got_rd[$], got_wr[$];
  logic [3:0] rd_be_q[$], s_be_q[$], got_rd_be[$], got_wr_be[$];
  byte dir_log[$];
  logic rxf_en, s_en;
  logic smp_rd_n, smp_oe_n, smp_wr_n;
  logic [31:0] smp_data;

  task automatic drive();
    ftdi_rxf_n = !(rxf_en && rd_q.size() > 0);
    host_word = rd_q.size() > 0 ? rd_q[0] : '0;
    host_be = rd_be_q.size() > 0 ? rd_be_q[0] : '0;
    s_axis_tvalid = s_en && s_q.size() > 0;
    s_axis_tdata = s_q.size() > 0 ? s_q[0] : IDLE_PAT;
    s_axis_tkeep = s_be_q.size() > 0 ? s_be_q[0] : 4'hF;
  endtask

  // FTDI side: pops a word whenever the sampled cycle carried a qualified transfer.
  task automatic step();
    logic rx, wx;
    @(negedge clk);
    smp_rd_n = ftdi_rd_n;
    smp_oe_n = ftdi_oe_n;
    smp_wr_n = ftdi_wr_n;
    smp_data = ftdi_data;
    rx = m_axis_tvalid;
    wx = s_axis_tvalid & s_axis_tready;
    if (rx) begin
      got_rd.push_back(m_axis_tdata);
      got_rd_be.push_back(m_axis_tkeep);
      dir_log.push_back(CR);
    end
    if (wx) begin
      got_wr.push_back(ftdi_data);
      got_wr_be.push_back(ftdi_be);
      dir_log.push_back(CW);
    end
    @(posedge clk);
    #1;
    if (rx) begin
      void'(rd_q.pop_front());
      void'(rd_be_q.pop_front());
    end
    if (wx) begin
      void'(s_q.pop_front());
      void'(s_be_q.pop_front());
    end
    drive();
  endtask

  task automatic do_reset();
    res = 1'b1;
    rd_q.delete(); rd_be_q.delete(); s_q.delete(); s_be_q.delete();
    got_rd.delete(); got_rd_be.delete(); got_wr.delete(); got_wr_be.delete(); dir_log.delete();
    rxf_en = 1'b0;
    s_en = 1'b0;
    ftdi_txe_n = 1'b1;
    m_axis_tready = 1'b1;
    m_axis_almost_full = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    drive();
  endtask

  task automatic fill_rd(input int n);
    for (int i = 0; i < n; i++) begin
      rd_q.push_back($urandom);
      rd_be_q.push_back(4'($urandom_range(15)));
    end
  endtask

  task automatic fill_wr(input int n);
    for (int i = 0; i < n; i++) begin
      s_q.push_back($urandom);
      s_be_q.push_back(4'($urandom_range(15)));
    end
  endtask

  task automatic test_reset();
    do_reset();
    res = 1'b1;
    #1;
    total++; if (ftdi_rd_n !== 1'b1) begin bad++; $display("FAIL reset_rd_n got=%b exp=1", ftdi_rd_n); end
    total++; if (ftdi_oe_n !== 1'b1) begin bad++; $display("FAIL reset_oe_n got=%b exp=1", ftdi_oe_n); end
    total++; if (ftdi_wr_n !== 1'b1) begin bad++; $display("FAIL reset_wr_n got=%b exp=1", ftdi_wr_n); end
    total++; if (rd_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", rd_overflow); end
    total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b exp=0", s_axis_tready); end
    total++; if (stat_rd_words !== 32'd0 || stat_wr_words !== 32'd0) begin
      bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_rd_words, stat_wr_words);
    end
    do_reset();
  endtask

  task automatic test_read();
    logic [31:0] exp_w[$];
    logic [3:0] exp_b[$];
    int oe_c, rd_c, turns;
    logic prev_rd_n;
    do_reset();
    fill_rd(10);
    exp_w = rd_q;
    exp_b = rd_be_q;
    rxf_en = 1'b1;
    drive();
    oe_c = -1; rd_c = -1; turns = 0; prev_rd_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (oe_c < 0 && smp_oe_n == 1'b0) oe_c = c;
      if (rd_c < 0 && smp_rd_n == 1'b0) rd_c = c;
      if (!prev_rd_n && smp_rd_n) begin
        turns++;
        total++; if (smp_oe_n !== 1'b1 || smp_data === IDLE_PAT) begin
          bad++; $display("FAIL read_turn oe_n=%b data=%h exp oe_n=1 bus released", smp_oe_n, smp_data);
        end
      end
      prev_rd_n = smp_rd_n;
    end
    total++; if (rd_c - oe_c !== 1) begin bad++; $display("FAIL read_oe_lead got=%0d exp=1", rd_c - oe_c); end
    total++; if (turns !== (10 + BM - 1) / BM) begin bad++; $display("FAIL read_turns got=%0d exp=%0d", turns, (10 + BM - 1) / BM); end
    total++; if (got_rd.size() !== 10) begin bad++; $display("FAIL read_count got=%0d exp=10", got_rd.size()); end
    for (int i = 0; i < 10 && i < got_rd.size(); i++) begin
      total++; if (got_rd[i] !== exp_w[i] || got_rd_be[i] !== exp_b[i]) begin
        bad++; $display("FAIL read_word[%0d] got=%h/%h exp=%h/%h", i, got_rd[i], got_rd_be[i], exp_w[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_write_stall();
    logic [31:0] exp_w[$];
    do_reset();
    fill_wr(5);
    exp_w = s_q;
    s_en = 1'b1;
    ftdi_txe_n = 1'b0;
    drive();
    for (int c = 0; c < 20 && got_wr.size() < 3; c++) step();
    ftdi_txe_n = 1'b1;
    for (int c = 0; c < 5; c++) step();
    total++; if (got_wr.size() !== 3) begin bad++; $display("FAIL wr_stall_pulses got=%0d exp=3", got_wr.size()); end
    total++; if (smp_wr_n !== 1'b1) begin bad++; $display("FAIL wr_stall_wr_n got=%b exp=1", smp_wr_n); end
    ftdi_txe_n = 1'b0;
    for (int c = 0; c < 20 && got_wr.size() < 5; c++) step();
    repeat (4) step();
    total++; if (got_wr.size() !== 5) begin bad++; $display("FAIL wr_resume_count got=%0d exp=5", got_wr.size()); end
    for (int i = 0; i < 5 && i < got_wr.size(); i++) begin
      total++; if (got_wr[i] !== exp_w[i]) begin bad++; $display("FAIL wr_word[%0d] got=%h exp=%h", i, got_wr[i], exp_w[i]); end
    end
  endtask

  task automatic test_round_robin();
    byte rd_dir[$];
    int rl[$];
    do_reset();
    fill_rd(12);
    fill_wr(12);
    rxf_en = 1'b1;
    s_en = 1'b1;
    ftdi_txe_n = 1'b0;
    drive();
    for (int c = 0; c < 200 && (rd_q.size() > 0 || s_q.size() > 0); c++) step();
    repeat (3) step();
    foreach (dir_log[i]) begin
      if (i == 0 || dir_log[i] != dir_log[i-1]) begin
        rd_dir.push_back(dir_log[i]);
        rl.push_back(1);
      end else rl[rl.size()-1]++;
    end
    total++; if (rl.size() !== 6) begin bad++; $display("FAIL rr_bursts got=%0d exp=6", rl.size()); end
    for (int i = 0; i < 6 && i < rl.size(); i++) begin
      total++; if (rd_dir[i] !== ((i % 2 == 0) ? CR : CW) || rl[i] !== BM) begin
        bad++; $display("FAIL rr_burst[%0d] got=%c%0d exp=%c%0d", i, rd_dir[i], rl[i], (i % 2 == 0) ? CR : CW, BM);
      end
    end
  endtask

  task automatic test_almost_full();
    logic [31:0] exp_w[$];
    do_reset();
    fill_rd(8);
    exp_w = rd_q;
    rxf_en = 1'b1;
    drive();
    for (int c = 0; c < 20 && got_rd.size() < 2; c++) step();
    m_axis_almost_full = 1'b1;
    repeat (6) step();
    total++; if (got_rd.size() > 3 || got_rd.size() < 2) begin bad++; $display("FAIL af_extra got=%0d exp<=1", got_rd.size() - 2); end
    total++; if (smp_rd_n !== 1'b1) begin bad++; $display("FAIL af_rd_n got=%b exp=1", smp_rd_n); end
    m_axis_almost_full = 1'b0;
    for (int c = 0; c < 60 && rd_q.size() > 0; c++) step();
    repeat (3) step();
    total++; if (rd_overflow !== 1'b0) begin bad++; $display("FAIL af_ovf got=%b exp=0", rd_overflow); end
    total++; if (got_rd != exp_w) begin bad++; $display("FAIL af_order got=%0d words exp=%0d in order", got_rd.size(), exp_w.size()); end
  endtask

  task automatic test_overflow_and_reset();
    do_reset();
    fill_rd(3);
    rxf_en = 1'b1;
    m_axis_tready = 1'b0;
    drive();
    for (int c = 0; c < 20 && got_rd.size() < 1; c++) step();
    m_axis_tready = 1'b1;
    total++; if (rd_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", rd_overflow); end
    repeat (10) step();
    total++; if (rd_overflow !== 1'b1) begin bad++; $display("FAIL ovf_hold got=%b exp=1", rd_overflow); end
    res = 1'b1;
    #1;
    total++; if (rd_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", rd_overflow); end
    do_reset();
    fill_wr(8);
    s_en = 1'b1;
    ftdi_txe_n = 1'b0;
    drive();
    for (int c = 0; c < 20 && got_wr.size() < 2; c++) step();
    total++; if (ftdi_wr_n !== 1'b0) begin bad++; $display("FAIL mid_wr_active got=%b exp=0", ftdi_wr_n); end
    res = 1'b1;
    #1;
    total++; if (ftdi_wr_n !== 1'b1 || s_axis_tready !== 1'b0) begin
      bad++; $display("FAIL mid_wr_reset wr_n=%b tready=%b exp=1/0", ftdi_wr_n, s_axis_tready);
    end
    do_reset();
  endtask

  task automatic test_tkeep();
    logic [31:0] w;
    do_reset();
    w = $urandom;
    s_q.push_back(w);
    s_be_q.push_back(4'b0011);
    s_en = 1'b1;
    ftdi_txe_n = 1'b0;
    drive();
    for (int c = 0; c < 10 && got_wr.size() < 1; c++) step();
    repeat (3) step();
    total++; if (got_wr.size() !== 1) begin bad++; $display("FAIL tkeep_count got=%0d exp=1", got_wr.size()); end
    else begin
      total++; if (got_wr_be[0] !== 4'b0011 || got_wr[0] !== w) begin
        bad++; $display("FAIL tkeep_be got=%b/%h exp=0011/%h", got_wr_be[0], got_wr[0], w);
      end
    end
`ifdef FTDI_STATS_EN
    total++; if (stat_wr_words !== 32'd1) begin bad++; $display("FAIL stat_wr got=%0d exp=1", stat_wr_words); end
`else
    total++; if (stat_wr_words !== 32'd0) begin bad++; $display("FAIL stat_wr got=%0d exp=0", stat_wr_words); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] exp_r[$], exp_wq[$];
    logic [3:0] exp_rb[$], exp_wb[$];
    do_reset();
    fill_rd(40);
    fill_wr(40);
    exp_r = rd_q; exp_rb = rd_be_q; exp_wq = s_q; exp_wb = s_be_q;
    for (int c = 0; c < 300; c++) begin
      rxf_en = 1'($urandom_range(1));
      s_en = 1'($urandom_range(1));
      ftdi_txe_n = 1'($urandom_range(1));
      m_axis_almost_full = $urandom_range(3) == 0;
      drive();
      step();
    end
    rxf_en = 1'b1; s_en = 1'b1; ftdi_txe_n = 1'b0; m_axis_almost_full = 1'b0;
    drive();
    for (int c = 0; c < 300 && (rd_q.size() > 0 || s_q.size() > 0); c++) step();
    repeat (3) step();
    total++; if (got_rd != exp_r || got_rd_be != exp_rb) begin bad++; $display("FAIL rand_read got=%0d words exp=%0d in order", got_rd.size(), exp_r.size()); end
    total++; if (got_wr != exp_wq || got_wr_be != exp_wb) begin bad++; $display("FAIL rand_write got=%0d words exp=%0d in order", got_wr.size(), exp_wq.size()); end
    total++; if (rd_overflow !== 1'b0) begin bad++; $display("FAIL rand_ovf got=%b exp=0", rd_overflow); end
`ifdef FTDI_STATS_EN
    total++; if (stat_rd_words !== 32'd40 || stat_wr_words !== 32'd40) begin
      bad++; $display("FAIL rand_stats got=%0d/%0d exp=40/40", stat_rd_words, stat_wr_words);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_round_robin();
    test_almost_full();
    test_overflow_and_reset();
    test_tkeep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
